// File: rtl/qu_decoder.sv
// qu_decoder: registered RV32I decoder with a two-entry (main/skid) output buffer.
// The optional macro QU_DECODER_ZICSR_EN enables decoding of the Zicsr
// instructions as class CSR. Without it they are reported as illegal.
module qu_decoder #(
  parameter int PC_WIDTH    = 12,
  parameter int XLEN        = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_WIDTH-1:0]    in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [3:0]             out_class,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [2:0]             out_funct3,
  output logic [6:0]             out_funct7,
  output logic [XLEN-1:0]        out_imm,
  output logic                   out_illegal,
  output logic [COUNT_WIDTH-1:0] dec_count
);

  localparam logic [3:0] C_ALU_R = 4'd0, C_ALU_I = 4'd1, C_LOAD = 4'd2, C_STORE = 4'd3,
                         C_BRANCH = 4'd4, C_JAL = 4'd5, C_JALR = 4'd6, C_LUI = 4'd7,
                         C_AUIPC = 4'd8, C_SYSTEM = 4'd9, C_CSR = 4'd10, C_FENCE = 4'd11,
                         C_ILL = 4'd15;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [3:0]          cls;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic [XLEN-1:0]     imm;
    logic                ill;
  } dec_t;

  // Sign-extend a 32-bit value to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic ill;
  dec_t dec;

  assign opc = in_instr[6:0];
  assign rd  = in_instr[11:7];
  assign f3  = in_instr[14:12];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign f7  = in_instr[31:25];
  assign imm_i = sext32({{20{in_instr[31]}}, in_instr[31:20]});
  assign imm_s = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
  assign imm_b = sext32({{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0});
  assign imm_u = sext32({in_instr[31:12], 12'b0});
  assign imm_j = sext32({{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0});

  // Combinational decode; illegal encodings collapse to class 15 with all fields cleared.
  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    dec.f3 = f3;
    ill    = (in_instr[1:0] != 2'b11);
    case (opc)
      7'b0110011: begin
        dec.cls = C_ALU_R; dec.rd = rd; dec.rs1 = rs1; dec.rs2 = rs2; dec.f7 = f7;
        if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
        if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
      end
      7'b0010011: begin
        dec.cls = C_ALU_I; dec.rd = rd; dec.rs1 = rs1; dec.imm = imm_i;
        if (f3 == 3'b001) begin
          dec.f7 = f7;
          if (f7 != 7'h00) ill = 1'b1;
        end else if (f3 == 3'b101) begin
          dec.f7 = f7;
          if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
        end
      end
      7'b0000011: begin
        dec.cls = C_LOAD; dec.rd = rd; dec.rs1 = rs1; dec.imm = imm_i;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      end
      7'b0100011: begin
        dec.cls = C_STORE; dec.rs1 = rs1; dec.rs2 = rs2; dec.imm = imm_s;
        if (f3 > 3'b010) ill = 1'b1;
      end
      7'b1100011: begin
        dec.cls = C_BRANCH; dec.rs1 = rs1; dec.rs2 = rs2; dec.imm = imm_b;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      7'b1101111: begin dec.cls = C_JAL; dec.rd = rd; dec.imm = imm_j; end
      7'b1100111: begin
        dec.cls = C_JALR; dec.rd = rd; dec.rs1 = rs1; dec.imm = imm_i;
        if (f3 != 3'b000) ill = 1'b1;
      end
      7'b0110111: begin dec.cls = C_LUI;   dec.rd = rd; dec.imm = imm_u; end
      7'b0010111: begin dec.cls = C_AUIPC; dec.rd = rd; dec.imm = imm_u; end
      7'b1110011: begin
        if (f3 == 3'b000) begin
          // Only ECALL (imm 0) and EBREAK (imm 1) with rd = rs1 = 0.
          dec.cls = C_SYSTEM; dec.imm = imm_i;
          if (in_instr[31:21] != 11'd0 || rs1 != 5'd0 || rd != 5'd0) ill = 1'b1;
        end else if (f3 == 3'b100) begin
          ill = 1'b1;
        end else begin
`ifdef QU_DECODER_ZICSR_EN
          // rs1 field doubles as the uimm for the immediate forms.
          dec.cls = C_CSR; dec.rd = rd; dec.rs1 = rs1; dec.imm = XLEN'(in_instr[31:20]);
`else
          ill = 1'b1;
`endif
        end
      end
      7'b0001111: begin
        dec.cls = C_FENCE; dec.rd = rd; dec.rs1 = rs1; dec.imm = imm_i;
        if (f3 != 3'b000 && f3 != 3'b001) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec     = '0;
      dec.pc  = in_pc;
      dec.cls = C_ILL;
      dec.ill = 1'b1;
    end
  end

  dec_t m_q, s_q, m_n, s_n;
  logic m_vld, s_vld, m_vld_n, s_vld_n, rdy_q;
  logic acc, drain;

  assign acc   = in_valid & rdy_q;
  assign drain = m_vld & out_ready;

  // Skid next-state: M refills from S first, else from the input; stalled M diverts input to S.
  always_comb begin
    m_n = m_q; s_n = s_q; m_vld_n = m_vld; s_vld_n = s_vld;
    if (flush) begin
      m_vld_n = 1'b0;
      s_vld_n = 1'b0;
    end else if (drain) begin
      if (s_vld) begin
        m_n = s_q; s_vld_n = 1'b0;
      end else if (acc) begin
        m_n = dec;
      end else begin
        m_vld_n = 1'b0;
      end
    end else if (!m_vld) begin
      if (acc) begin m_n = dec; m_vld_n = 1'b1; end
    end else if (acc) begin
      s_n = dec; s_vld_n = 1'b1;
    end
  end

  // Buffer state registers; in_ready is registered as "S will be empty".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q <= '0; s_q <= '0; m_vld <= 1'b0; s_vld <= 1'b0; rdy_q <= 1'b1;
    end else begin
      m_q <= m_n; s_q <= s_n; m_vld <= m_vld_n; s_vld <= s_vld_n; rdy_q <= !s_vld_n;
    end
  end

  // Completed output handshakes; flush does not clear it.
  always_ff @(posedge clk) begin
    if (!rst_n)     dec_count <= '0;
    else if (drain) dec_count <= dec_count + 1'b1;
  end

  assign in_ready    = rdy_q;
  assign out_valid   = m_vld;
  assign out_pc      = m_q.pc;
  assign out_class   = m_q.cls;
  assign out_rd      = m_q.rd;
  assign out_rs1     = m_q.rs1;
  assign out_rs2     = m_q.rs2;
  assign out_funct3  = m_q.f3;
  assign out_funct7  = m_q.f7;
  assign out_imm     = m_q.imm;
  assign out_illegal = m_q.ill;

endmodule

// File: tb/tb_qu_decoder.sv
// Directed self-checking bench for qu_decoder (default parameters).
module tb_qu_decoder;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [11:0] in_pc = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [11:0] out_pc;
  logic [3:0]  out_class;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic [15:0] dec_count;

  int total = 0, bad = 0;
  logic [15:0] exp_cnt = '0;

  qu_decoder dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_illegal(out_illegal), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one instruction with out_ready high; it sits in M after the edge.
  task automatic send_one(input logic [31:0] ins, input logic [11:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Let the instruction currently in M drain.
  task automatic drain_one();
    step();
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 12'h123;
    step(); step();
    rst_n = 1'b1; in_valid = 1'b0; exp_cnt = '0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    total++; if (dec_count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", dec_count); end
    total++; if ({out_pc, out_class, out_imm, out_illegal} !== '0) begin bad++; $display("FAIL rst_fields got pc=%h cls=%0d imm=%h ill=%b want all 0", out_pc, out_class, out_imm, out_illegal); end
  endtask

  task automatic test_alu_i();
    send_one(32'hFFF10093, 12'h100);  // addi x1, x2, -1
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b want=1", out_valid); end
    total++; if ({out_class, out_rd, out_rs1, out_rs2} !== {4'd1, 5'd1, 5'd2, 5'd0}) begin bad++; $display("FAIL addi_fields got cls=%0d rd=%0d rs1=%0d rs2=%0d want 1/1/2/0", out_class, out_rd, out_rs1, out_rs2); end
    total++; if ({out_imm, out_illegal, out_pc} !== {32'hFFFFFFFF, 1'b0, 12'h100}) begin bad++; $display("FAIL addi_imm got imm=%h ill=%b pc=%h want ffffffff/0/100", out_imm, out_illegal, out_pc); end
    drain_one();
    send_one(32'h40315093, 12'h104);  // srai x1, x2, 3
    total++; if ({out_class, out_funct3, out_funct7, out_imm} !== {4'd1, 3'd5, 7'h20, 32'h00000403}) begin bad++; $display("FAIL srai got cls=%0d f3=%0d f7=%h imm=%h want 1/5/20/00000403", out_class, out_funct3, out_funct7, out_imm); end
    drain_one();
  endtask

  task automatic test_formats();
    send_one(32'hFE208EE3, 12'h200);  // beq x1, x2, -4
    total++; if ({out_class, out_rd, out_rs1, out_rs2, out_imm} !== {4'd4, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC}) begin bad++; $display("FAIL beq got cls=%0d rd=%0d rs1=%0d rs2=%0d imm=%h want 4/0/1/2/fffffffc", out_class, out_rd, out_rs1, out_rs2, out_imm); end
    drain_one();
    send_one(32'h00322423, 12'h204);  // sw x3, 8(x4)
    total++; if ({out_class, out_rd, out_rs1, out_rs2, out_funct3, out_imm} !== {4'd3, 5'd0, 5'd4, 5'd3, 3'd2, 32'd8}) begin bad++; $display("FAIL sw got cls=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h want 3/0/4/3/2/8", out_class, out_rd, out_rs1, out_rs2, out_funct3, out_imm); end
    drain_one();
    send_one(32'h123452B7, 12'h208);  // lui x5, 0x12345
    total++; if ({out_class, out_rd, out_rs1, out_imm} !== {4'd7, 5'd5, 5'd0, 32'h12345000}) begin bad++; $display("FAIL lui got cls=%0d rd=%0d rs1=%0d imm=%h want 7/5/0/12345000", out_class, out_rd, out_rs1, out_imm); end
    drain_one();
    send_one(32'h008000EF, 12'h20C);  // jal x1, 8
    total++; if ({out_class, out_rd, out_imm} !== {4'd5, 5'd1, 32'd8}) begin bad++; $display("FAIL jal got cls=%0d rd=%0d imm=%h want 5/1/8", out_class, out_rd, out_imm); end
    drain_one();
    send_one(32'h00100073, 12'h210);  // ebreak
    total++; if ({out_class, out_imm, out_illegal} !== {4'd9, 32'd1, 1'b0}) begin bad++; $display("FAIL ebreak got cls=%0d imm=%h ill=%b want 9/1/0", out_class, out_imm, out_illegal); end
    drain_one();
    total++; if (dec_count !== exp_cnt) begin bad++; $display("FAIL fmt_count got=%0d want=%0d", dec_count, exp_cnt); end
  endtask

  task automatic test_illegal();
    logic [31:0] vecs [3];
    vecs[0] = 32'h00000000; vecs[1] = 32'h40004033; vecs[2] = 32'h00003067;
    for (int i = 0; i < 3; i++) begin
      send_one(vecs[i], 12'h300 + 12'(i));
      total++; if ({out_class, out_illegal, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm} !== {4'd15, 1'b1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0}) begin bad++; $display("FAIL illegal_%0d got cls=%0d ill=%b rd=%0d rs1=%0d f3=%0d imm=%h want 15/1 rest 0", i, out_class, out_illegal, out_rd, out_rs1, out_funct3, out_imm); end
      total++; if (out_pc !== 12'h300 + 12'(i)) begin bad++; $display("FAIL illegal_pc_%0d got=%h want=%h", i, out_pc, 12'h300 + 12'(i)); end
      drain_one();
    end
  endtask

  task automatic test_csr();
    send_one(32'h300110F3, 12'h400);  // csrrw x1, 0x300, x2
`ifdef QU_DECODER_ZICSR_EN
    total++; if ({out_class, out_rd, out_rs1, out_imm, out_illegal} !== {4'd10, 5'd1, 5'd2, 32'h300, 1'b0}) begin bad++; $display("FAIL csrrw got cls=%0d rd=%0d rs1=%0d imm=%h ill=%b want 10/1/2/300/0", out_class, out_rd, out_rs1, out_imm, out_illegal); end
`else
    total++; if ({out_class, out_rd, out_rs1, out_imm, out_illegal} !== {4'd15, 5'd0, 5'd0, 32'h0, 1'b1}) begin bad++; $display("FAIL csrrw got cls=%0d rd=%0d rs1=%0d imm=%h ill=%b want 15/0/0/0/1", out_class, out_rd, out_rs1, out_imm, out_illegal); end
`endif
    drain_one();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'hFFF10093; in_pc = 12'h010; step();   // A -> M
    in_instr = 32'h123452B7; in_pc = 12'h014; step();   // B -> S
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b want=0", in_ready); end
    in_instr = 32'h008000EF; in_pc = 12'h018; step();   // C held off
    total++; if ({out_valid, out_pc, out_class} !== {1'b1, 12'h010, 4'd1}) begin bad++; $display("FAIL b2b_stall got v=%b pc=%h cls=%0d want 1/010/1", out_valid, out_pc, out_class); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready got=%b want=0", in_ready); end
    out_ready = 1'b1; step(); exp_cnt++;                 // A out, B -> M
    total++; if ({out_pc, out_class, in_ready} !== {12'h014, 4'd7, 1'b1}) begin bad++; $display("FAIL b2b_second got pc=%h cls=%0d rdy=%b want 014/7/1", out_pc, out_class, in_ready); end
    step(); exp_cnt++;                                   // B out, C -> M
    total++; if ({out_valid, out_pc, out_class} !== {1'b1, 12'h018, 4'd5}) begin bad++; $display("FAIL b2b_third got v=%b pc=%h cls=%0d want 1/018/5", out_valid, out_pc, out_class); end
    in_valid = 1'b0; step(); exp_cnt++;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b want=0", out_valid); end
    total++; if (dec_count !== exp_cnt) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", dec_count, exp_cnt); end
  endtask

  task automatic fill_both();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'hFFF10093; in_pc = 12'h020; step();
    in_instr = 32'h00322423; in_pc = 12'h024; step();
  endtask

  task automatic test_flush();
    fill_both();
    in_instr = 32'h008000EF; flush = 1'b1; step(); flush = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL flush_full got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    total++; if (dec_count !== exp_cnt) begin bad++; $display("FAIL flush_count got=%0d want=%0d", dec_count, exp_cnt); end
    flush = 1'b1; step(); flush = 1'b0;                  // in_valid=1, in_ready=1: accepted then discarded
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_accept got v=%b want=0", out_valid); end
    in_valid = 1'b0; step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_accept_late got v=%b want=0", out_valid); end
    send_one(32'hFFF10093, 12'h030);
    flush = 1'b1; step(); flush = 1'b0; exp_cnt++;       // handshake during flush still counts
    total++; if ({out_valid, dec_count} !== {1'b0, exp_cnt}) begin bad++; $display("FAIL flush_hs got v=%b cnt=%0d want 0/%0d", out_valid, dec_count, exp_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    fill_both();
    rst_n = 1'b0; step(); rst_n = 1'b1; in_valid = 1'b0; exp_cnt = '0;
    total++; if ({out_valid, in_ready, dec_count} !== {1'b0, 1'b1, 16'd0}) begin bad++; $display("FAIL rst_stall got v=%b rdy=%b cnt=%0d want 0/1/0", out_valid, in_ready, dec_count); end
    total++; if ({out_pc, out_class, out_imm} !== '0) begin bad++; $display("FAIL rst_stall_fields got pc=%h cls=%0d imm=%h want 0", out_pc, out_class, out_imm); end
  endtask

  initial begin
    test_reset();
    test_alu_i();
    test_formats();
    test_illegal();
    test_csr();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
